lsu_initiator: RTL and testbench

- Load/store initiator between the pipeline MEM-stage control and the 256x16 word-addressed data memory port (memread, memwrite, addr, wd, rd).
- Accepts one request at a time from the pipeline over a valid/ready handshake and drives the memory strobes for a programmable number of cycles.
- Captures load data and returns a response over a valid/ready handshake.
- Flags misaligned and out-of-range addresses without touching memory, and keeps saturating activity counters for debug.

---
 rtl/lsu_initiator_if.sv | 28 ++
 rtl/lsu_initiator.sv | 116 +++++++++++
 tb/tb_lsu_initiator.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_initiator_if.sv
// Pipeline request/response handshake plus data-memory port of the load/store initiator.
// The master modport is the initiator's view; slave is the pipeline/memory side.
interface lsu_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        memread;
   logic        memwrite;
   logic [15:0] addr;
   logic [15:0] wd;
   logic [15:0] rd;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready, rd,
      output req_ready, resp_valid, resp_rdata, resp_err, memread, memwrite, addr, wd
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, resp_ready, rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, memread, memwrite, addr, wd
   );
endinterface

// File: rtl/lsu_initiator.sv
// Load/store initiator: carries one pipeline request at a time onto the word-addressed data
// memory, rejects misaligned/out-of-range addresses and keeps saturating debug counters.
module lsu_initiator #(
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   lsu_initiator_if.master  bus,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   // state  | meaning
   // IDLE   | ready for a request, memory port quiet
   // ACCESS | strobe held while the wait counter runs down to 0
   // RESP   | response presented until resp_ready
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  wait_cnt;
   logic        we_q;
   logic        err_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;

   logic        legal;
   logic        accept;
   logic        last_wait;
   logic        resp_done;

   assign legal     = (bus.req_addr[1:0] == 2'b00) && (bus.req_addr[15:10] == 6'd0);
   assign last_wait = (wait_cnt == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      resp_done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (last_wait) state_nxt = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode straight from state so an async reset drops the strobes at once.
   always_comb begin
      bus.req_ready  = (state == IDLE) && !rst;
      bus.memread    = (state == ACCESS) && !we_q;
      bus.memwrite   = (state == ACCESS) && we_q;
      bus.addr       = (state == ACCESS) ? addr_q : 16'd0;
      bus.wd         = (state == ACCESS) ? wdata_q : 16'd0;
      bus.resp_valid = (state == RESP);
      bus.resp_rdata = (state == RESP) ? rdata_q : 16'd0;
      bus.resp_err   = (state == RESP) && err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 4'd0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= 16'd0;
         wdata_q  <= 16'd0;
         rdata_q  <= 16'd0;
      end else if (accept) begin
         wait_cnt <= WAIT_LOAD;
         we_q     <= bus.req_we;
         err_q    <= !legal;
         addr_q   <= bus.req_addr;
         wdata_q  <= bus.req_wdata;
         rdata_q  <= 16'd0;
      end else if (state == ACCESS) begin
         if (!last_wait)  wait_cnt <= wait_cnt - 4'd1;
         else if (!we_q)  rdata_q  <= bus.rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt  <= '0;
         store_cnt <= '0;
         err_cnt   <= '0;
      end else if (resp_done) begin
         if (err_q) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         end else if (we_q) begin
            if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
         end else begin
            if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lsu_initiator.sv
// Bench for lsu_initiator: two instances (WAIT_CYCLES=1/CNT_W=16 and WAIT_CYCLES=3/CNT_W=2)
// against a transaction-timeline model, plus directed literal checks.
module tb_lsu_initiator;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_d;
   logic [1:0]  req_valid_d;
   logic [1:0]  req_we_d;
   logic [1:0]  resp_ready_d;
   logic [15:0] req_addr_d [2];
   logic [15:0] req_wdata_d [2];

   lsu_initiator_if ifa ();
   lsu_initiator_if ifb ();

   logic [15:0] lc0, sc0, ec0;
   logic [1:0]  lc1, sc1, ec1;

   lsu_initiator #(.WAIT_CYCLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst_d[0]), .bus(ifa), .load_cnt(lc0), .store_cnt(sc0), .err_cnt(ec0));
   lsu_initiator #(.WAIT_CYCLES(3), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst_d[1]), .bus(ifb), .load_cnt(lc1), .store_cnt(sc1), .err_cnt(ec1));

   assign ifa.req_valid  = req_valid_d[0];
   assign ifa.req_we     = req_we_d[0];
   assign ifa.req_addr   = req_addr_d[0];
   assign ifa.req_wdata  = req_wdata_d[0];
   assign ifa.resp_ready = resp_ready_d[0];
   assign ifb.req_valid  = req_valid_d[1];
   assign ifb.req_we     = req_we_d[1];
   assign ifb.req_addr   = req_addr_d[1];
   assign ifb.req_wdata  = req_wdata_d[1];
   assign ifb.resp_ready = resp_ready_d[1];

   logic [1:0]  o_ready, o_mr, o_mw, o_valid, o_err;
   logic [15:0] o_addr [2];
   logic [15:0] o_wd [2];
   logic [15:0] o_rdata [2];
   logic [15:0] o_lc [2];
   logic [15:0] o_sc [2];
   logic [15:0] o_ec [2];
   assign o_ready  = {ifb.req_ready, ifa.req_ready};
   assign o_mr     = {ifb.memread, ifa.memread};
   assign o_mw     = {ifb.memwrite, ifa.memwrite};
   assign o_valid  = {ifb.resp_valid, ifa.resp_valid};
   assign o_err    = {ifb.resp_err, ifa.resp_err};
   assign o_addr[0]  = ifa.addr;       assign o_addr[1]  = ifb.addr;
   assign o_wd[0]    = ifa.wd;         assign o_wd[1]    = ifb.wd;
   assign o_rdata[0] = ifa.resp_rdata; assign o_rdata[1] = ifb.resp_rdata;
   assign o_lc[0] = lc0; assign o_lc[1] = {14'd0, lc1};
   assign o_sc[0] = sc0; assign o_sc[1] = {14'd0, sc1};
   assign o_ec[0] = ec0; assign o_ec[1] = {14'd0, ec1};

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] init_word(input int w);
      case (w)
         0:       return 16'h5A5A;
         8:       return 16'hA5A5;
         255:     return 16'h1234;
         default: return 16'h1000 + 16'(w);
      endcase
   endfunction

   // Emulated data memory, one per instance; rd is combinational from addr.
   logic [15:0] mem [2][256];
   bit mem_loaded = 1'b0;
   assign ifa.rd = mem[0][ifa.addr[9:2]];
   assign ifb.rd = mem[1][ifb.addr[9:2]];
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 2; i++)
            for (int w = 0; w < 256; w++) mem[i][w] <= init_word(w);
         mem_loaded <= 1'b1;
      end else begin
         if (ifa.memwrite) mem[0][ifa.addr[9:2]] <= ifa.wd;
         if (ifb.memwrite) mem[1][ifb.addr[9:2]] <= ifb.wd;
      end
   end

   // Model: a request accepted at edge T owns cycles T+1.. ; strobe in T+1..T+W,
   // response from T+W+1 (T+1 for errors) until the resp handshake.
   int          cyc = 0;
   bit          ref_loaded = 1'b0;
   logic [15:0] ref_mem [2][256];
   bit          m_active [2];
   int          m_t [2];
   bit          m_err [2];
   bit          m_we [2];
   logic [15:0] m_addr [2];
   logic [15:0] m_wdata [2];
   logic [15:0] m_rdata [2];
   int          m_lc [2];
   int          m_sc [2];
   int          m_ec [2];

   function automatic int wait_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int cmax(input int i);
      return (i == 0) ? 65535 : 3;
   endfunction

   function automatic bit exp_valid(input int i, input int c);
      if (!m_active[i]) return 1'b0;
      return m_err[i] ? (c - m_t[i] >= 1) : (c - m_t[i] >= wait_of(i) + 1);
   endfunction

   function automatic bit exp_strobe(input int i, input int c);
      return m_active[i] && !m_err[i] && (c - m_t[i] >= 1) && (c - m_t[i] <= wait_of(i));
   endfunction

   always @(posedge clk) begin
      if (!ref_loaded) begin
         for (int i = 0; i < 2; i++)
            for (int w = 0; w < 256; w++) ref_mem[i][w] = init_word(w);
         ref_loaded = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         if (rst_d[i]) begin
            m_active[i] = 1'b0;
            m_lc[i] = 0; m_sc[i] = 0; m_ec[i] = 0;
         end else if (m_active[i]) begin
            if (exp_valid(i, cyc) && resp_ready_d[i]) begin
               m_active[i] = 1'b0;
               if (m_err[i])     m_ec[i] = (m_ec[i] < cmax(i)) ? m_ec[i] + 1 : m_ec[i];
               else if (m_we[i]) m_sc[i] = (m_sc[i] < cmax(i)) ? m_sc[i] + 1 : m_sc[i];
               else              m_lc[i] = (m_lc[i] < cmax(i)) ? m_lc[i] + 1 : m_lc[i];
            end
         end else if (req_valid_d[i]) begin
            m_active[i] = 1'b1;
            m_t[i]      = cyc;
            m_we[i]     = req_we_d[i];
            m_addr[i]   = req_addr_d[i];
            m_wdata[i]  = req_wdata_d[i];
            m_err[i]    = !(req_addr_d[i] < 16'h0400 && req_addr_d[i] % 4 == 0);
            m_rdata[i]  = (m_err[i] || m_we[i]) ? 16'd0 : ref_mem[i][req_addr_d[i] / 4];
            if (!m_err[i] && m_we[i]) ref_mem[i][req_addr_d[i] / 4] = req_wdata_d[i];
         end
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      bit          e_ready, e_rd, e_wr, e_valid, st;
      logic [15:0] e_addr, e_wd;
      int          e_lc, e_sc, e_ec;
      for (int i = 0; i < 2; i++) begin
         if (rst_d[i]) begin
            e_ready = 0; e_rd = 0; e_wr = 0; e_valid = 0;
            e_addr = 16'd0; e_wd = 16'd0; e_lc = 0; e_sc = 0; e_ec = 0;
         end else begin
            st      = exp_strobe(i, cyc);
            e_ready = !m_active[i];
            e_rd    = st && !m_we[i];
            e_wr    = st && m_we[i];
            e_addr  = st ? m_addr[i] : 16'd0;
            e_wd    = st ? m_wdata[i] : 16'd0;
            e_valid = exp_valid(i, cyc);
            e_lc = m_lc[i]; e_sc = m_sc[i]; e_ec = m_ec[i];
         end
         chk("req_ready", i, 32'(o_ready[i]), 32'(e_ready));
         chk("memread", i, 32'(o_mr[i]), 32'(e_rd));
         chk("memwrite", i, 32'(o_mw[i]), 32'(e_wr));
         chk("addr", i, 32'(o_addr[i]), 32'(e_addr));
         chk("wd", i, 32'(o_wd[i]), 32'(e_wd));
         chk("resp_valid", i, 32'(o_valid[i]), 32'(e_valid));
         chk("load_cnt", i, 32'(o_lc[i]), 32'(e_lc));
         chk("store_cnt", i, 32'(o_sc[i]), 32'(e_sc));
         chk("err_cnt", i, 32'(o_ec[i]), 32'(e_ec));
         if (e_valid) begin
            chk("resp_rdata", i, 32'(o_rdata[i]), 32'(m_rdata[i]));
            chk("resp_err", i, 32'(o_err[i]), 32'(m_err[i]));
         end
      end
   end

   // Returns #1 after the accepting edge.
   task automatic issue(input int i, input bit we, input logic [15:0] a, input logic [15:0] d);
      bit ok = 1'b0;
      @(negedge clk);
      req_we_d[i]    = we;
      req_addr_d[i]  = a;
      req_wdata_d[i] = d;
      req_valid_d[i] = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(posedge clk); #1;
         if (m_active[i] && m_t[i] == cyc - 1) ok = 1'b1;
      end
      req_valid_d[i] = 1'b0;
      if (!ok) begin
         failures++;
         $display("FAIL accept_timeout dut%0d: request %0h not taken within 20 cycles", i, a);
      end
   endtask

   task automatic observe(input int i, input int n, input bit wr,
                          output int scnt, output int sfirst, output int slast,
                          output int vfirst, output logic [15:0] vdata, output logic verr,
                          output logic [15:0] saddr, output logic [15:0] swd, output bit rdy);
      scnt = 0; sfirst = 0; slast = 0; vfirst = 0; vdata = 16'd0; verr = 1'b0;
      saddr = 16'd0; swd = 16'd0; rdy = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (wr ? o_mw[i] : o_mr[i]) begin
            scnt++;
            if (sfirst == 0) begin
               sfirst = k; saddr = o_addr[i]; swd = o_wd[i];
            end
            slast = k;
         end
         if (vfirst == 0 && o_ready[i]) rdy = 1'b1;
         if (vfirst == 0 && o_valid[i]) begin
            vfirst = k; vdata = o_rdata[i]; verr = o_err[i];
         end
      end
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while (m_active[i] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (m_active[i]) begin
         failures++;
         $display("FAIL idle_timeout dut%0d: response not completed within 40 cycles", i);
      end
   endtask

   initial begin
      int          sc, sf, sl, vf;
      logic [15:0] vd, sa, sw;
      logic        ve;
      bit          rdy;
      int          exp_sat [5] = '{1, 2, 3, 3, 3};

      rst_d = 2'b00; req_valid_d = 2'b00; req_we_d = 2'b00; resp_ready_d = 2'b11;
      for (int i = 0; i < 2; i++) begin
         req_addr_d[i] = 16'd0; req_wdata_d[i] = 16'd0;
      end
      #1 rst_d = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_req_ready", i, 32'(o_ready[i]), 0);
         chk("rst_resp_valid", i, 32'(o_valid[i]), 0);
         chk("rst_memread", i, 32'(o_mr[i]), 0);
      end
      @(negedge clk);
      rst_d = 2'b00;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rel_req_ready", i, 32'(o_ready[i]), 1);
         chk("rel_store_cnt", i, 32'(o_sc[i]), 0);
      end

      // store then load, WAIT_CYCLES=1
      issue(0, 1'b1, 16'h0010, 16'hBEEF);
      observe(0, 4, 1'b1, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("st_strobes", 0, sc, 1);
      chk("st_addr", 0, 32'(sa), 32'h0010);
      chk("st_wd", 0, 32'(sw), 32'hBEEF);
      chk("st_vfirst", 0, vf, 2);
      chk("st_err", 0, 32'(ve), 0);
      chk("st_rdata", 0, 32'(vd), 0);
      wait_idle(0);
      chk("st_cnt", 0, 32'(o_sc[0]), 1);

      issue(0, 1'b0, 16'h0010, 16'h0000);
      observe(0, 4, 1'b0, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("ld_strobes", 0, sc, 1);
      chk("ld_vfirst", 0, vf, 2);
      chk("ld_rdata", 0, 32'(vd), 32'hBEEF);
      chk("ld_ready_busy", 0, 32'(rdy), 0);
      wait_idle(0);
      chk("ld_cnt", 0, 32'(o_lc[0]), 1);

      // error responses
      issue(0, 1'b0, 16'h0011, 16'h0000);
      observe(0, 3, 1'b0, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("misal_strobes", 0, sc, 0);
      chk("misal_vfirst", 0, vf, 1);
      chk("misal_err", 0, 32'(ve), 1);
      chk("misal_rdata", 0, 32'(vd), 0);
      wait_idle(0);
      chk("misal_err_cnt", 0, 32'(o_ec[0]), 1);
      chk("misal_load_cnt", 0, 32'(o_lc[0]), 1);

      issue(0, 1'b1, 16'h0400, 16'hDEAD);
      observe(0, 3, 1'b1, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("oor_strobes", 0, sc, 0);
      chk("oor_vfirst", 0, vf, 1);
      chk("oor_err", 0, 32'(ve), 1);
      chk("oor_rdata", 0, 32'(vd), 0);
      wait_idle(0);
      chk("oor_err_cnt", 0, 32'(o_ec[0]), 2);
      chk("oor_store_cnt", 0, 32'(o_sc[0]), 1);
      chk("oor_mem_kept", 0, 32'(mem[0][0]), 32'h5A5A);

      // WAIT_CYCLES=3 load at top of range
      issue(1, 1'b0, 16'h03FC, 16'h0000);
      observe(1, 6, 1'b0, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("w3_strobes", 1, sc, 3);
      chk("w3_first", 1, sf, 1);
      chk("w3_last", 1, sl, 3);
      chk("w3_vfirst", 1, vf, 4);
      chk("w3_rdata", 1, 32'(vd), 32'h1234);
      chk("w3_ready_busy", 1, 32'(rdy), 0);
      wait_idle(1);
      chk("w3_load_cnt", 1, 32'(o_lc[1]), 1);

      // response backpressure
      resp_ready_d[0] = 1'b0;
      issue(0, 1'b0, 16'h0020, 16'h0000);
      observe(0, 2, 1'b0, sc, sf, sl, vf, vd, ve, sa, sw, rdy);
      chk("bp_vfirst", 0, vf, 2);
      chk("bp_rdata", 0, 32'(vd), 32'hA5A5);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("bp_hold_valid", 0, 32'(o_valid[0]), 1);
         chk("bp_hold_rdata", 0, 32'(o_rdata[0]), 32'hA5A5);
         chk("bp_hold_ready", 0, 32'(o_ready[0]), 0);
         chk("bp_hold_strobe", 0, 32'(o_mr[0] | o_mw[0]), 0);
      end
      resp_ready_d[0] = 1'b1;
      @(negedge clk);
      chk("bp_rel_ready", 0, 32'(o_ready[0]), 1);
      chk("bp_rel_valid", 0, 32'(o_valid[0]), 0);
      chk("bp_load_cnt", 0, 32'(o_lc[0]), 2);

      // reset in the second memread cycle
      issue(1, 1'b0, 16'h0020, 16'h0000);
      @(posedge clk);
      #2;
      chk("mid_memread_pre", 1, 32'(o_mr[1]), 1);
      #1 rst_d[1] = 1'b1;
      #1;
      chk("mid_memread_drop", 1, 32'(o_mr[1]), 0);
      chk("mid_valid", 1, 32'(o_valid[1]), 0);
      chk("mid_ready", 1, 32'(o_ready[1]), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_d[1] = 1'b0;
      #1;
      chk("mid_rel_ready", 1, 32'(o_ready[1]), 1);
      chk("mid_rel_load_cnt", 1, 32'(o_lc[1]), 0);
      chk("mid_rel_store_cnt", 1, 32'(o_sc[1]), 0);
      chk("mid_rel_err_cnt", 1, 32'(o_ec[1]), 0);
      repeat (6) begin
         @(negedge clk);
         chk("mid_no_resp", 1, 32'(o_valid[1]), 0);
      end

      // 2-bit counter saturation
      for (int n = 0; n < 5; n++) begin
         issue(1, 1'b1, 16'h0040, 16'h0100 + 16'(n));
         wait_idle(1);
         chk("sat_store_cnt", 1, 32'(o_sc[1]), 32'(exp_sat[n]));
      end
      chk("sat_load_cnt", 1, 32'(o_lc[1]), 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
